ekf_cmd_sequencer: RTL and testbench
====================================

Name: ekf_cmd_sequencer

Overview:
- Second-generation EKF command sequencer. It sits between the SPI command/response link and the predict/update datapath plus the shared state memory.
- Additions over the first generation:
  - region-based memory addressing for x, P and z;
  - length checking;
  - multi-iteration RUN_FULL;
  - predict/update timeouts;
  - burst read-out with a correctly pipelined memory read;
  - a structured status word that terminates every command.

Parameters:
- STATE_DIM, 4, state vector length N.
- MEAS_DIM, 2, measurement vector length M.
- DATA_WIDTH, 32, memory/payload word width; must be >= 24.
- TIMEOUT_CYCLES, 4096, maximum cycles allowed between a start pulse and its done.
- ADDR_W, $clog2(N*N+N+M), memory address width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command strobe
- cmd_ready  out  1  high only in IDLE
- cmd  in  8  opcode
- payload_length  in  8  word count (load) or iteration count (RUN_FULL); sampled with cmd
- payload_data  in  DATA_WIDTH  load data
- payload_valid  in  1  load data valid
- payload_ready  out  1  high only in LOAD
- response_data  out  DATA_WIDTH  read data or status word
- response_valid  out  1  response word valid
- response_last  out  1  marks the status word
- response_ready  in  1  host accepts the response word
- predict_start  out  1  one-cycle pulse
- predict_done  in  1  predict complete
- update_start  out  1  one-cycle pulse
- update_done  in  1  update complete
- mem_wr_en  out  1  memory write enable
- mem_rd_en  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_WIDTH  memory write data
- mem_rd_data  in  DATA_WIDTH  valid one cycle after mem_rd_en

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous, active-low. Reset forces:
  - state to IDLE;
  - all outputs to 0, except cmd_ready = 1;
  - all counters and registers to 0.
  - Reset mid-command abandons the command: no status word is sent and no memory write is issued.
- Memory regions:
  - x: base 0, length N.
  - P: base N, length N*N.
  - z: base N+N*N, length M.
- Opcodes:
  - 01 LOAD_X, 02 LOAD_P, 03 LOAD_Z.
  - 10 PREDICT, 11 UPDATE, 12 FULL.
  - 20 READ_X, 21 READ_P, 22 READ_Z.
- Command accept: on cmd_valid & cmd_ready, latch cmd and payload_length, clear the index and iteration counters.
  - Unknown opcode: go to STATUS with code 01.
  - Load or read whose payload_length differs from the region length: go to STATUS with code 02; no memory access.
- LOAD:
  - Each payload_valid cycle writes mem_addr = base + idx and increments idx.
  - The write with idx = len-1 moves to STATUS with code 00.
- PREDICT / UPDATE:
  - The start pulse is asserted in the first cycle of the state; the timeout counter is cleared at the same time.
  - done moves PREDICT→STATUS (cmd 10), UPDATE→STATUS (cmd 11).
  - FULL runs PREDICT→UPDATE; each update_done increments iter.
    - If iter < max(payload_length,1), return to PREDICT (new start pulse).
    - Otherwise go to STATUS.
  - A done arriving in the same cycle as the start pulse is accepted.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without done, go to STATUS with code 03.
  - done asserted outside PREDICT/UPDATE is ignored.
- READ: RD_ADDR → RD_WAIT → RD_SEND.
  - RD_ADDR: assert mem_rd_en, mem_addr = base + idx.
  - RD_WAIT: capture mem_rd_data into the response buffer.
  - RD_SEND: response_valid = 1, response_last = 0. On handshake, increment idx.
  - Next state after the handshake: RD_ADDR if idx < len-1, otherwise STATUS.
  - While response_ready is low, data is held stable.
- STATUS:
  - Drives response_valid = 1, response_last = 1.
  - response_data: [7:0] code, [15:8] cmd, [23:16] iter, upper bits 0.
  - Handshake returns to IDLE. cmd_ready rises the following cycle.
- Write/read exclusivity: mem_wr_en and mem_rd_en are never high together; mem_addr is 0 when both are low.

Optional Feature:
- Macro: EKF_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort high in any state other than IDLE or STATUS forces STATUS with code 04 in the next cycle.
  - Any pending LOAD write in that cycle is suppressed.
  - Priority of abort: above done, timeout and handshakes.
- Undefined: the port does not exist; behaviour is otherwise identical.

Test Plan:
- LOAD_X, length 4, data 0xA0..0xA3 with payload_valid gapped every other cycle → writes at addresses 0..3; status 0x00000100 with last=1.
- LOAD_P, length 15 (N=4) → no mem_wr_en; status code 02, word 0x00000202.
- FULL, payload_length=3, done 5 cycles after each start → 3 predict_start and 3 update_start pulses; status 0x00031200.
- PREDICT with predict_done never asserted, TIMEOUT_CYCLES=16 → status 0x00001003 emitted 16 cycles after the start pulse.
- Memory preloaded with z = {0x11,0x22}; READ_Z, length 2, response_ready low for 3 cycles on the first word → data words 0x11, 0x22 (held stable while stalled), then status 0x00002200 with last=1.
- With EKF_SEQ_ABORT_EN: abort mid-LOAD_P after 5 words → exactly 5 writes; status 0x00000204. Separately, assert rst_n low mid-READ → all outputs 0 and cmd_ready=1 immediately.

Source files
------------

// File: rtl/ekf_cmd_sequencer.sv
// EKF command sequencer: SPI command link -> predict/update datapath + state memory.
// Optional abort input is enabled by defining EKF_SEQ_ABORT_EN.
module ekf_cmd_sequencer #(
    parameter int  STATE_DIM      = 4,
    parameter int  MEAS_DIM       = 2,
    parameter int  DATA_WIDTH     = 32,
    parameter int  TIMEOUT_CYCLES = 4096,
    localparam int ADDR_W = $clog2(STATE_DIM*STATE_DIM + STATE_DIM + MEAS_DIM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd,
    input  logic [7:0]            payload_length,
    input  logic [DATA_WIDTH-1:0] payload_data,
    input  logic                  payload_valid,
    output logic                  payload_ready,
    output logic [DATA_WIDTH-1:0] response_data,
    output logic                  response_valid,
    output logic                  response_last,
    input  logic                  response_ready,
    output logic                  predict_start,
    input  logic                  predict_done,
    output logic                  update_start,
    input  logic                  update_done,
`ifdef EKF_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int N     = STATE_DIM;
    localparam int M     = MEAS_DIM;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] OP_LOAD_X  = 8'h01;
    localparam logic [7:0] OP_LOAD_P  = 8'h02;
    localparam logic [7:0] OP_LOAD_Z  = 8'h03;
    localparam logic [7:0] OP_PREDICT = 8'h10;
    localparam logic [7:0] OP_UPDATE  = 8'h11;
    localparam logic [7:0] OP_FULL    = 8'h12;
    localparam logic [7:0] OP_READ_X  = 8'h20;
    localparam logic [7:0] OP_READ_P  = 8'h21;
    localparam logic [7:0] OP_READ_Z  = 8'h22;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_BADOP  = 8'h01;
    localparam logic [7:0] ST_BADLEN = 8'h02;
    localparam logic [7:0] ST_TMO    = 8'h03;
    localparam logic [7:0] ST_ABORT  = 8'h04;

    localparam logic [1:0] RG_X = 2'd0;
    localparam logic [1:0] RG_P = 2'd1;
    localparam logic [1:0] RG_Z = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRED,
        S_UPD,
        S_RD_ADDR,
        S_RD_WAIT,
        S_RD_SEND,
        S_STATUS
    } state_e;

    state_e                state_q;
    logic [7:0]            cmd_q;
    logic [7:0]            len_q;
    logic [7:0]            idx_q;
    logic [7:0]            iter_q;
    logic [7:0]            code_q;
    logic [1:0]            region_q;
    logic [TMO_W-1:0]      tmo_q;
    logic [DATA_WIDTH-1:0] rbuf_q;
    logic                  pstart_q;
    logic                  ustart_q;

    logic                  dec_load;
    logic                  dec_read;
    logic                  dec_known;
    logic [1:0]            dec_region;
    logic                  abort_hit;
    logic [7:0]            iter_max;
    logic                  iter_more;
    logic [ADDR_W-1:0]     acc_addr;
    logic [DATA_WIDTH-1:0] status_word;

    function automatic logic [7:0] region_len(input logic [1:0] r);
        case (r)
            RG_P:    return 8'(N * N);
            RG_Z:    return 8'(M);
            default: return 8'(N);
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] region_base(input logic [1:0] r);
        case (r)
            RG_P:    return ADDR_W'(N);
            RG_Z:    return ADDR_W'(N + N * N);
            default: return '0;
        endcase
    endfunction

    // Classify the incoming opcode and pick its memory region
    always_comb begin
        dec_load   = 1'b0;
        dec_read   = 1'b0;
        dec_known  = 1'b1;
        dec_region = RG_X;
        case (cmd)
            OP_LOAD_X: dec_load = 1'b1;
            OP_LOAD_P: begin
                dec_load   = 1'b1;
                dec_region = RG_P;
            end
            OP_LOAD_Z: begin
                dec_load   = 1'b1;
                dec_region = RG_Z;
            end
            OP_READ_X: dec_read = 1'b1;
            OP_READ_P: begin
                dec_read   = 1'b1;
                dec_region = RG_P;
            end
            OP_READ_Z: begin
                dec_read   = 1'b1;
                dec_region = RG_Z;
            end
            OP_PREDICT, OP_UPDATE, OP_FULL: dec_known = 1'b1;
            default: dec_known = 1'b0;
        endcase
    end

`ifdef EKF_SEQ_ABORT_EN
    assign abort_hit = abort && (state_q != S_IDLE)
                     && (state_q != S_STATUS);
`else
    assign abort_hit = 1'b0;
`endif

    // A RUN_FULL with iteration count 0 still runs one iteration
    assign iter_max    = (len_q == 8'd0) ? 8'd1 : len_q;
    assign iter_more   = (iter_q + 8'd1) < iter_max;
    assign acc_addr    = region_base(region_q) + ADDR_W'(idx_q);
    assign status_word = DATA_WIDTH'({iter_q, cmd_q, code_q});

    assign cmd_ready      = (state_q == S_IDLE);
    assign payload_ready  = (state_q == S_LOAD);
    assign response_valid = (state_q == S_RD_SEND) || (state_q == S_STATUS);
    assign response_last  = (state_q == S_STATUS);
    assign predict_start  = pstart_q;
    assign update_start   = ustart_q;
    assign mem_wr_en      = (state_q == S_LOAD) && payload_valid && !abort_hit;
    assign mem_rd_en      = (state_q == S_RD_ADDR);
    assign mem_addr       = (mem_wr_en || mem_rd_en) ? acc_addr : '0;
    assign mem_wr_data    = mem_wr_en ? payload_data : '0;
    assign response_data  = (state_q == S_RD_SEND) ? rbuf_q
                          : (state_q == S_STATUS)  ? status_word
                          : '0;

    // Command FSM with all sequencing registers and start pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            iter_q   <= '0;
            code_q   <= '0;
            region_q <= '0;
            tmo_q    <= '0;
            rbuf_q   <= '0;
            pstart_q <= 1'b0;
            ustart_q <= 1'b0;
        end else begin
            pstart_q <= 1'b0;
            ustart_q <= 1'b0;
            if (abort_hit) begin
                state_q <= S_STATUS;
                code_q  <= ST_ABORT;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            cmd_q    <= cmd;
                            len_q    <= payload_length;
                            region_q <= dec_region;
                            idx_q    <= '0;
                            iter_q   <= '0;
                            code_q   <= ST_OK;
                            tmo_q    <= '0;
                            if (!dec_known) begin
                                state_q <= S_STATUS;
                                code_q  <= ST_BADOP;
                            end else if ((dec_load || dec_read) &&
                                    payload_length != region_len(dec_region)) begin
                                state_q <= S_STATUS;
                                code_q  <= ST_BADLEN;
                            end else if (dec_load) begin
                                state_q <= S_LOAD;
                            end else if (dec_read) begin
                                state_q <= S_RD_ADDR;
                            end else if (cmd == OP_UPDATE) begin
                                state_q  <= S_UPD;
                                ustart_q <= 1'b1;
                            end else begin
                                state_q  <= S_PRED;
                                pstart_q <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (payload_valid) begin
                            idx_q <= idx_q + 8'd1;
                            if (idx_q == len_q - 8'd1) begin
                                state_q <= S_STATUS;
                            end
                        end
                    end
                    S_PRED: begin
                        if (predict_done) begin
                            if (cmd_q == OP_FULL) begin
                                state_q  <= S_UPD;
                                ustart_q <= 1'b1;
                                tmo_q    <= '0;
                            end else begin
                                state_q <= S_STATUS;
                            end
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= S_STATUS;
                            code_q  <= ST_TMO;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    S_UPD: begin
                        if (update_done) begin
                            if (cmd_q == OP_FULL) begin
                                iter_q <= iter_q + 8'd1;
                                if (iter_more) begin
                                    state_q  <= S_PRED;
                                    pstart_q <= 1'b1;
                                    tmo_q    <= '0;
                                end else begin
                                    state_q <= S_STATUS;
                                end
                            end else begin
                                state_q <= S_STATUS;
                            end
                        end else if (tmo_q == TMO_LAST) begin
                            state_q <= S_STATUS;
                            code_q  <= ST_TMO;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    S_RD_ADDR: state_q <= S_RD_WAIT;
                    S_RD_WAIT: begin
                        rbuf_q  <= mem_rd_data;
                        state_q <= S_RD_SEND;
                    end
                    S_RD_SEND: begin
                        if (response_ready) begin
                            idx_q <= idx_q + 8'd1;
                            if (idx_q < len_q - 8'd1) begin
                                state_q <= S_RD_ADDR;
                            end else begin
                                state_q <= S_STATUS;
                            end
                        end
                    end
                    S_STATUS: begin
                        if (response_ready) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ekf_cmd_sequencer.sv
// Bench for ekf_cmd_sequencer: directed cases plus random commands
// checked against a transaction-level model of the command set.
module tb_ekf_cmd_sequencer;

    localparam int N      = 4;
    localparam int M      = 2;
    localparam int DW     = 32;
    localparam int TMO    = 16;
    localparam int MEM_SZ = N * N + N + M;
    localparam int AW     = $clog2(MEM_SZ);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [7:0]    cmd = '0;
    logic [7:0]    payload_length = '0;
    logic [DW-1:0] payload_data = '0;
    logic          payload_valid = 1'b0;
    logic          payload_ready;
    logic [DW-1:0] response_data;
    logic          response_valid;
    logic          response_last;
    logic          response_ready;
    logic          predict_start;
    logic          predict_done;
    logic          update_start;
    logic          update_done;
    logic          mem_wr_en;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data = '0;
`ifdef EKF_SEQ_ABORT_EN
    logic          abort = 1'b0;
`endif

    ekf_cmd_sequencer #(
        .STATE_DIM     (N),
        .MEAS_DIM      (M),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd           (cmd),
        .payload_length(payload_length),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .payload_ready (payload_ready),
        .response_data (response_data),
        .response_valid(response_valid),
        .response_last (response_last),
        .response_ready(response_ready),
        .predict_start (predict_start),
        .predict_done  (predict_done),
        .update_start  (update_start),
        .update_done   (update_done),
`ifdef EKF_SEQ_ABORT_EN
        .abort         (abort),
`endif
        .mem_wr_en     (mem_wr_en),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_rd_data   (mem_rd_data)
    );

    always #5 clk = ~clk;

    // counters and reference state
    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    logic [DW-1:0] tb_mem [MEM_SZ] = '{default: '0};
    logic [DW-1:0] ref_mem [MEM_SZ];
    logic [DW-1:0] pdata [256];

    // datapath responder knobs: <0 never, 0 same cycle, k cycles later
    int   plat = 1;
    int   ulat = 1;
    int   p_cnt = 0;
    int   u_cnt = 0;
    logic stray_done = 1'b0;

    // response-ready knobs
    logic rnd_ready = 1'b0;
    logic ready_off = 1'b0;
    int   stall_left = 0;

    // monitor observations (cumulative)
    int            obs_wa [$];
    logic [DW-1:0] obs_wd [$];
    logic [DW-1:0] obs_rd [$];
    logic          obs_rl [$];
    int            n_pst = 0;
    int            n_ust = 0;
    int            n_status = 0;
    int            excl_err = 0;
    int            hold_err = 0;
    int            t_pst = 0;
    int            t_stv = 0;
    logic          prev_stv = 1'b0;
    logic          held = 1'b0;
    logic [DW-1:0] held_val = '0;

    // model expectations
    int            exp_wa [$];
    logic [DW-1:0] exp_wd [$];
    logic [DW-1:0] exp_rsp [$];
    int            exp_np;
    int            exp_nu;

    // snapshots taken before each command
    int s_wr, s_rd, s_pst, s_ust, s_st, s_ex, s_ho;

    always @(posedge clk) cyc <= cyc + 1;

    // state memory with one-cycle read latency
    always @(posedge clk) begin
        if (mem_wr_en && int'(mem_addr) < MEM_SZ)
            tb_mem[mem_addr] <= mem_wr_data;
        if (mem_rd_en)
            mem_rd_data <= (int'(mem_addr) < MEM_SZ) ? tb_mem[mem_addr] : '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_cnt <= 0;
            u_cnt <= 0;
        end else begin
            if (predict_start && plat > 0) p_cnt <= plat;
            else if (p_cnt > 0) p_cnt <= p_cnt - 1;
            if (update_start && ulat > 0) u_cnt <= ulat;
            else if (u_cnt > 0) u_cnt <= u_cnt - 1;
        end
    end

    assign predict_done = stray_done || (predict_start && plat == 0) || (p_cnt == 1);
    assign update_done  = stray_done || (update_start && ulat == 0) || (u_cnt == 1);

    initial begin
        response_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_off) begin
                response_ready = 1'b0;
            end else if (stall_left > 0 && response_valid) begin
                response_ready = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                response_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr_en) begin
                obs_wa.push_back(int'(mem_addr));
                obs_wd.push_back(mem_wr_data);
            end
            if ((mem_wr_en && mem_rd_en) ||
                (!mem_wr_en && !mem_rd_en && mem_addr != '0))
                excl_err <= excl_err + 1;
            if (predict_start) begin
                n_pst <= n_pst + 1;
                t_pst <= cyc;
            end
            if (update_start) n_ust <= n_ust + 1;
            if (response_valid && response_last && !prev_stv) t_stv <= cyc;
            prev_stv <= response_valid && response_last;
            if (response_valid && held && response_data != held_val)
                hold_err <= hold_err + 1;
            held     <= response_valid && !response_ready;
            held_val <= response_data;
            if (response_valid && response_ready) begin
                obs_rd.push_back(response_data);
                obs_rl.push_back(response_last);
                if (response_last) n_status <= n_status + 1;
            end
        end else begin
            held     <= 1'b0;
            prev_stv <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int kind_of(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03: return 1;
            8'h20, 8'h21, 8'h22: return 2;
            8'h10: return 3;
            8'h11: return 4;
            8'h12: return 5;
            default: return 0;
        endcase
    endfunction

    function automatic int base_of(input logic [7:0] op);
        case (op[1:0] + (op[5] ? 2'd1 : 2'd0))
            2'd2:    return N;
            2'd3:    return N + N * N;
            default: return 0;
        endcase
    endfunction

    function automatic int rlen_of(input logic [7:0] op);
        case (op[1:0] + (op[5] ? 2'd1 : 2'd0))
            2'd2:    return N * N;
            2'd3:    return M;
            default: return N;
        endcase
    endfunction

    // What one command should do, from the opcode table alone
    task automatic model_cmd(input logic [7:0] op, input logic [7:0] len);
        int         k, b, rl, n;
        logic [7:0] code, iter;
        k = kind_of(op);
        b = base_of(op);
        rl = rlen_of(op);
        code = 8'h00;
        iter = 8'h00;
        exp_wa.delete();
        exp_wd.delete();
        exp_rsp.delete();
        exp_np = 0;
        exp_nu = 0;
        if (k == 0) begin
            code = 8'h01;
        end else if ((k == 1 || k == 2) && int'(len) != rl) begin
            code = 8'h02;
        end else if (k == 1) begin
            for (int i = 0; i < rl; i++) begin
                exp_wa.push_back(b + i);
                exp_wd.push_back(pdata[i]);
                ref_mem[b + i] = pdata[i];
            end
        end else if (k == 2) begin
            for (int i = 0; i < rl; i++) exp_rsp.push_back(ref_mem[b + i]);
        end else if (k == 3) begin
            exp_np = 1;
            if (plat < 0) code = 8'h03;
        end else if (k == 4) begin
            exp_nu = 1;
            if (ulat < 0) code = 8'h03;
        end else begin
            n = (len == 0) ? 1 : int'(len);
            exp_np = n;
            exp_nu = n;
            iter = 8'(n);
        end
        exp_rsp.push_back(DW'({iter, op, code}));
    endtask

    task automatic snap();
        s_wr  = obs_wa.size();
        s_rd  = obs_rd.size();
        s_pst = n_pst;
        s_ust = n_ust;
        s_st  = n_status;
        s_ex  = excl_err;
        s_ho  = hold_err;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] len);
        int w;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        cmd = op;
        payload_length = len;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic exec_cmd(input logic [7:0] op, input logic [7:0] len,
                            input int gap, input int abort_at);
        int w;
        send_cmd(op, len);
        if (payload_ready) begin
            for (int i = 0; i < int'(len); i++) begin
                payload_data  = pdata[i];
                payload_valid = 1'b1;
`ifdef EKF_SEQ_ABORT_EN
                if (i == abort_at) abort = 1'b1;
`endif
                @(posedge clk);
                #1;
                payload_valid = 1'b0;
                if (i == abort_at) begin
`ifdef EKF_SEQ_ABORT_EN
                    abort = 1'b0;
`endif
                    break;
                end
                if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        w = 0;
        while (n_status == s_st && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("status_seen", 64'(n_status - s_st), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        int nw, nr, last;
        nw = obs_wa.size() - s_wr;
        nr = obs_rd.size() - s_rd;
        chk({tag, "_nwr"}, 64'(nw), 64'(exp_wa.size()));
        if (nw == exp_wa.size()) begin
            for (int i = 0; i < nw; i++) begin
                chk({tag, "_waddr"}, 64'(obs_wa[s_wr + i]), 64'(exp_wa[i]));
                chk({tag, "_wdata"}, 64'(obs_wd[s_wr + i]), 64'(exp_wd[i]));
            end
        end
        chk({tag, "_nrsp"}, 64'(nr), 64'(exp_rsp.size()));
        if (nr == exp_rsp.size()) begin
            last = nr - 1;
            for (int i = 0; i < nr; i++) begin
                chk({tag, "_rsp"}, 64'(obs_rd[s_rd + i]), 64'(exp_rsp[i]));
                chk({tag, "_last"}, 64'(obs_rl[s_rd + i]), 64'(i == last));
            end
        end
        chk({tag, "_npst"}, 64'(n_pst - s_pst), 64'(exp_np));
        chk({tag, "_nust"}, 64'(n_ust - s_ust), 64'(exp_nu));
        chk({tag, "_excl"}, 64'(excl_err - s_ex), 64'd0);
        chk({tag, "_hold"}, 64'(hold_err - s_ho), 64'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] op,
                           input logic [7:0] len, input int gap);
        model_cmd(op, len);
        snap();
        exec_cmd(op, len, gap, -1);
        compare(tag);
    endtask

    initial begin
        logic [7:0] op;
        logic [7:0] len;
        logic [7:0] bad_ops [5];
        logic [7:0] good_ops [9];
        int         w;
        bad_ops  = '{8'h00, 8'h04, 8'h13, 8'h23, 8'hFF};
        good_ops = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h11,
                     8'h12, 8'h20, 8'h21, 8'h22};
        for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = '0;
        for (int i = 0; i < 256; i++) pdata[i] = $urandom;

        // reset values while rst_n is held low
        #12;
        chk("rst0_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst0_ctl", 64'({payload_ready, response_valid, response_last,
            predict_start, update_start, mem_wr_en, mem_rd_en, mem_addr}), 64'd0);
        chk("rst0_data", 64'({response_data, mem_wr_data}), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // done pulses while idle change nothing
        stray_done = 1'b1;
        @(posedge clk);
        #1;
        stray_done = 1'b0;
        @(posedge clk);
        #1;
        chk("stray_idle", 64'({cmd_ready, response_valid, predict_start}), 64'b100);

        for (int i = 0; i < 4; i++) pdata[i] = DW'(32'hA0 + i);
        run_cmd("load_x", 8'h01, 8'd4, 1);
        chk("load_x_status", 64'(obs_rd[obs_rd.size() - 1]), 64'h100);

        run_cmd("load_p_badlen", 8'h02, 8'd15, 0);
        chk("badlen_status", 64'(obs_rd[obs_rd.size() - 1]), 64'h202);

        plat = 5;
        ulat = 5;
        run_cmd("full3", 8'h12, 8'd3, 0);
        chk("full3_status", 64'(obs_rd[obs_rd.size() - 1]), 64'h31200);

        plat = 0;
        ulat = 0;
        run_cmd("full0", 8'h12, 8'd0, 0);

        ulat = 2;
        run_cmd("update", 8'h11, 8'd0, 0);

        plat = -1;
        run_cmd("pred_tmo", 8'h10, 8'd0, 0);
        chk("tmo_status", 64'(obs_rd[obs_rd.size() - 1]), 64'h1003);
        chk("tmo_latency", 64'(t_stv - t_pst), 64'(TMO));
        plat = 1;

        pdata[0] = 32'h11;
        pdata[1] = 32'h22;
        run_cmd("load_z", 8'h03, 8'd2, 0);
        stall_left = 3;
        run_cmd("read_z", 8'h22, 8'd2, 0);
        chk("read_z_stat", 64'(obs_rd[obs_rd.size() - 1]), 64'h2200);

        run_cmd("read_p", 8'h21, 8'd16, 0);
        run_cmd("badop", 8'h33, 8'd4, 0);

`ifdef EKF_SEQ_ABORT_EN
        // abort after five P words: only those five land in memory
        for (int i = 0; i < 16; i++) pdata[i] = $urandom;
        exp_wa.delete();
        exp_wd.delete();
        exp_rsp.delete();
        for (int i = 0; i < 5; i++) begin
            exp_wa.push_back(N + i);
            exp_wd.push_back(pdata[i]);
            ref_mem[N + i] = pdata[i];
        end
        exp_rsp.push_back(32'h204);
        exp_np = 0;
        exp_nu = 0;
        snap();
        exec_cmd(8'h02, 8'd16, 0, 5);
        compare("abort");
`endif

        // random command mix
        rnd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) op = bad_ops[$urandom_range(0, 4)];
            else op = good_ops[$urandom_range(0, 8)];
            if (kind_of(op) == 5) len = 8'($urandom_range(0, 3));
            else if ((kind_of(op) == 1 || kind_of(op) == 2) && $urandom_range(0, 3) != 0)
                len = 8'(rlen_of(op));
            else len = 8'($urandom_range(0, 20));
            plat = $urandom_range(0, 10);
            ulat = $urandom_range(0, 10);
            for (int i = 0; i < 16; i++) pdata[i] = $urandom;
            run_cmd("rnd", op, len, 2);
        end
        rnd_ready = 1'b0;

        // reset in the middle of a read abandons it
        ready_off = 1'b1;
        snap();
        send_cmd(8'h20, 8'd4);
        w = 0;
        while (!response_valid && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("mid_rd_reached", 64'(response_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst1_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst1_ctl", 64'({payload_ready, response_valid, response_last,
            predict_start, update_start, mem_wr_en, mem_rd_en, mem_addr}), 64'd0);
        chk("rst1_data", 64'({response_data, mem_wr_data}), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        ready_off = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst1_nostatus", 64'(n_status - s_st), 64'd0);
        chk("rst1_nowrite", 64'(obs_wa.size() - s_wr), 64'd0);
        chk("rst1_idle", 64'(cmd_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
